// File: rtl/bnn_infer_ctrl.sv
// bnn_infer_ctrl: launch/collect controller between the image buffer and the BNN core.
// On accept, the de-padded image is snapshotted. The snapshot is then walked through an
// IN_STAGES-deep pipeline that advances once per divided-clock tick. While the core runs,
// a level core_start is held. The result is registered and result_ready stays set until
// bnn_clear.
// Optional watchdog: define BNN_IF_TIMEOUT_EN to enable the INFER-state timeout.
module bnn_infer_ctrl #(
    parameter int IMG_W        = 900,
    parameter int PAD_W        = 4,
    parameter int RES_W        = 4,
    parameter int IN_STAGES    = 2,
    parameter int CLK_DIV_LOG2 = 2,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IMG_W+PAD_W-1:0] img_in,
    input  logic                   img_buffer_full,
    input  logic                   bnn_enable,
    input  logic                   bnn_clear,
    output logic [RES_W-1:0]       result_out,
    output logic                   result_ready,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [IMG_W-1:0]       core_img,
    output logic                   core_start,
    input  logic [RES_W-1:0]       core_result,
    input  logic                   core_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        INFER  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // A zero-bit divider is not legal, so keep one bit and hold it at zero.
    localparam int DIV_W = (CLK_DIV_LOG2 > 0) ? CLK_DIV_LOG2 : 1;

    state_e                          state_q, state_d;
    logic [DIV_W-1:0]                div_q, div_d;
    logic                            tick;
    logic [IN_STAGES-1:0]            tok_q, tok_d;
    // Stage 0 is the snapshot; stage IN_STAGES drives the core.
    logic [IN_STAGES:0][IMG_W-1:0]   pipe_q, pipe_d;
    logic [RES_W-1:0]                res_q, res_d;
    logic                            accept;
    logic                            wd_hit;
    logic [PAD_W-1:0]                unused_pad;

    assign accept     = img_buffer_full & bnn_enable;
    assign unused_pad = img_in[PAD_W-1:0];

    // Free-running tick divider: tick whenever the count wraps through zero.
    always_comb begin
        if (CLK_DIV_LOG2 == 0) begin
            div_d = '0;
            tick  = 1'b1;
        end else begin
            div_d = div_q + 1'b1;
            tick  = (div_q == '0);
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

`ifdef BNN_IF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    // The watchdog counts every clk spent in INFER and restarts from zero on each entry.
    // A clear or a core_done in the final cycle takes priority over the timeout.
    always_comb begin
        wd_d   = (state_q == INFER) ? wd_q + 1'b1 : '0;
        wd_hit = (state_q == INFER) && (wd_q == WD_W'(TIMEOUT_CYC - 1));
        to_d   = to_q;
        if ((state_q == IDLE) && accept) begin
            to_d = 1'b0;
        end else if (wd_hit && !bnn_clear && !core_done) begin
            to_d = 1'b1;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_err = to_q;
`else
    logic unused_timeout;

    assign wd_hit         = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = |TIMEOUT_CYC;
`endif

    // FSM next state plus the token/snapshot pipeline and result capture.
    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        pipe_d  = pipe_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = LAUNCH;
                    pipe_d[0] = img_in[IMG_W+PAD_W-1:PAD_W];
                    tok_d     = '0;
                    tok_d[0]  = 1'b1;
                end
            end
            LAUNCH: begin
                if (bnn_clear) begin
                    state_d = IDLE;
                    tok_d   = '0;
                end else if (tick) begin
                    for (int i = 1; i <= IN_STAGES; i++) begin
                        pipe_d[i] = pipe_q[i-1];
                    end
                    tok_d = tok_q << 1;
                    // The token enters the last stage on this tick, and the core can start.
                    if (tok_q[IN_STAGES-1]) begin
                        state_d = INFER;
                        tok_d   = '0;
                    end
                end
            end
            INFER: begin
                if (bnn_clear) begin
                    state_d = IDLE;
                end else if (core_done) begin
                    res_d   = core_result;
                    state_d = DONE;
                end else if (wd_hit) begin
                    res_d   = '1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bnn_clear) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, token, pipeline and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tok_q   <= '0;
            pipe_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            pipe_q  <= pipe_d;
            res_q   <= res_d;
        end
    end

    // Status and core handshake are decoded from state so reset drops them immediately.
    assign core_start   = (state_q == INFER);
    assign busy         = (state_q == LAUNCH) || (state_q == INFER);
    assign result_ready = (state_q == DONE);
    assign result_out   = res_q;
    assign core_img     = pipe_q[IN_STAGES];

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Directed testbench for bnn_infer_ctrl (IN_STAGES=3, CLK_DIV_LOG2=2, TIMEOUT_CYC=16).
module tb_bnn_infer_ctrl;

    localparam int IMG_W        = 900;
    localparam int PAD_W        = 4;
    localparam int RES_W        = 4;
    localparam int IN_STAGES    = 3;
    localparam int CLK_DIV_LOG2 = 2;
    localparam int TIMEOUT_CYC  = 16;

    logic                   clk;
    logic                   rst_n;
    logic [IMG_W+PAD_W-1:0] img_in;
    logic                   img_buffer_full;
    logic                   bnn_enable;
    logic                   bnn_clear;
    logic [RES_W-1:0]       result_out;
    logic                   result_ready;
    logic                   busy;
    logic                   timeout_err;
    logic [IMG_W-1:0]       core_img;
    logic                   core_start;
    logic [RES_W-1:0]       core_result;
    logic                   core_done;

    int ncmp = 0;
    int nerr = 0;

    bnn_infer_ctrl #(
        .IMG_W       (IMG_W),
        .PAD_W       (PAD_W),
        .RES_W       (RES_W),
        .IN_STAGES   (IN_STAGES),
        .CLK_DIV_LOG2(CLK_DIV_LOG2),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .img_in         (img_in),
        .img_buffer_full(img_buffer_full),
        .bnn_enable     (bnn_enable),
        .bnn_clear      (bnn_clear),
        .result_out     (result_out),
        .result_ready   (result_ready),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .core_img       (core_img),
        .core_start     (core_start),
        .core_result    (core_result),
        .core_done      (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Wait (bounded) for core_start; n is the number of negedges waited.
    task automatic wait_start(output int n);
        n = 0;
        while (core_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("core_start_seen", core_start, 1);
    endtask

    initial begin
        int n;
        int seen;
        logic [IMG_W-1:0] pat1;
        logic [IMG_W-1:0] pat2;

        pat1 = {225{4'h5}};
        pat2 = {225{4'h9}};

        rst_n           = 1'b0;
        img_in          = '0;
        img_buffer_full = 1'b0;
        bnn_enable      = 1'b0;
        bnn_clear       = 1'b0;
        core_result     = '0;
        core_done       = 1'b0;
        repeat (3) step();

        chk("rst_result_out", result_out, 0);
        chk("rst_result_ready", result_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_img_zero", {63'd0, core_img === '0}, 1);
        rst_n = 1'b1;
        step();

        // Normal run: snapshot, latency, result 7.
        img_in          = {pat1, 4'hC};
        img_buffer_full = 1'b1;
        bnn_enable      = 1'b1;
        step();
        img_in          = '1;
        img_buffer_full = 1'b0;
        chk("a_busy_after_accept", busy, 1);
        chk("a_start_low_in_launch", core_start, 0);
        wait_start(n);
        chk("a_latency_8_to_12", {63'd0, (n >= 8 && n <= 12)}, 1);
        chk("a_core_img_snapshot", {63'd0, core_img === pat1}, 1);
        step();
        chk("a_start_held", core_start, 1);
        chk("a_ready_low_in_infer", result_ready, 0);
        chk("a_core_img_stable", {63'd0, core_img === pat1}, 1);
        core_done   = 1'b1;
        core_result = 4'd7;
        step();
        core_done   = 1'b0;
        core_result = 4'd0;
        chk("a_ready_set", result_ready, 1);
        chk("a_result_7", result_out, 7);
        chk("a_start_dropped", core_start, 0);
        chk("a_busy_dropped", busy, 0);
        repeat (3) step();
        chk("a_ready_sticky", result_ready, 1);
        chk("a_result_held", result_out, 7);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
        chk("a_ready_cleared", result_ready, 0);
        chk("a_result_kept", result_out, 7);

        // Abort during INFER, then a late core_done is ignored.
        img_in          = {pat2, 4'h3};
        img_buffer_full = 1'b1;
        step();
        img_buffer_full = 1'b0;
        wait_start(n);
        chk("b_core_img_snapshot", {63'd0, core_img === pat2}, 1);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
        chk("b_abort_start_low", core_start, 0);
        chk("b_abort_idle", busy, 0);
        core_done   = 1'b1;
        core_result = 4'd5;
        step();
        core_done   = 1'b0;
        core_result = 4'd0;
        chk("b_no_ready", result_ready, 0);
        chk("b_result_unchanged", result_out, 7);
        chk("b_still_idle", busy, 0);

        // Same-cycle clear and core_done: clear wins.
        img_buffer_full = 1'b1;
        step();
        img_buffer_full = 1'b0;
        wait_start(n);
        bnn_clear   = 1'b1;
        core_done   = 1'b1;
        core_result = 4'd9;
        step();
        bnn_clear   = 1'b0;
        core_done   = 1'b0;
        core_result = 4'd0;
        chk("c_no_ready", result_ready, 0);
        chk("c_idle", busy, 0);
        chk("c_result_unchanged", result_out, 7);
        img_buffer_full = 1'b1;
        step();
        img_buffer_full = 1'b0;
        wait_start(n);
        chk("c_rerun_latency", {63'd0, (n >= 8 && n <= 12)}, 1);
        core_done   = 1'b1;
        core_result = 4'd3;
        step();
        core_done   = 1'b0;
        core_result = 4'd0;
        chk("c_rerun_ready", result_ready, 1);
        chk("c_rerun_result_3", result_out, 3);

        // Accept while in DONE and during DONE->IDLE is ignored.
        img_buffer_full = 1'b1;
        step();
        chk("d_accept_in_done_ignored", busy, 0);
        chk("d_ready_still_set", result_ready, 1);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
        chk("d_clear_cycle_no_accept", busy, 0);
        chk("d_ready_cleared", result_ready, 0);
        step();
        img_buffer_full = 1'b0;
        chk("d_accept_next_cycle", busy, 1);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
        chk("d_launch_abort_idle", busy, 0);
        seen = 0;
        repeat (16) begin
            step();
            if (core_start === 1'b1) seen = 1;
        end
        chk("d_no_start_after_abort", seen, 0);

        // core_done in IDLE is ignored.
        core_done   = 1'b1;
        core_result = 4'hA;
        step();
        core_done   = 1'b0;
        core_result = 4'd0;
        chk("e_idle_done_no_ready", result_ready, 0);
        chk("e_idle_done_result_kept", result_out, 3);

        // Full without enable does not launch.
        bnn_enable      = 1'b0;
        img_buffer_full = 1'b1;
        step();
        step();
        chk("f_no_enable_idle", busy, 0);
        img_buffer_full = 1'b0;
        bnn_enable      = 1'b1;

        // Silent core.
        img_buffer_full = 1'b1;
        step();
        img_buffer_full = 1'b0;
        wait_start(n);
`ifdef BNN_IF_TIMEOUT_EN
        repeat (15) step();
        chk("g_start_before_timeout", core_start, 1);
        chk("g_ready_before_timeout", result_ready, 0);
        step();
        chk("g_timeout_ready", result_ready, 1);
        chk("g_timeout_err", timeout_err, 1);
        chk("g_timeout_result_f", result_out, 4'hF);
        chk("g_timeout_start_low", core_start, 0);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
        chk("g_err_held_after_clear", timeout_err, 1);
        img_buffer_full = 1'b1;
        step();
        img_buffer_full = 1'b0;
        chk("g_err_cleared_on_accept", timeout_err, 0);
        chk("g_busy_after_accept", busy, 1);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
`else
        repeat (40) step();
        chk("g_waits_forever_start", core_start, 1);
        chk("g_no_timeout_err", timeout_err, 0);
        chk("g_no_ready", result_ready, 0);
        bnn_clear = 1'b1;
        step();
        bnn_clear = 1'b0;
`endif
        chk("g_final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
